// File: rtl/image_loader_pp.sv
// Ping-pong image buffer: one bank is loaded over AXI4-Lite while the other
// streams out as an AXI-Stream frame of N_WORDS 32-bit words.
module image_loader_pp #(
    parameter int N_WORDS    = 784,
    parameter int AXI_ADDR_W = 12,
    parameter int CNT_W      = 16
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic                  start,

    input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,

    output logic [31:0]           x_tdata,
    output logic                  x_tvalid,
    input  logic                  x_tready,
    output logic                  x_tlast
);

    localparam int IDX_W = AXI_ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N_WORDS);
    localparam logic [IDX_W-1:0] CSR_IDX  = '1;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             wr_bank_q, wr_bank_d;
    logic             dropped_q, dropped_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_map_q, rd_map_d;
    logic             rd_csr_q, rd_csr_d;
    logic             rd_bank_q, rd_bank_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;

    logic [IDX_W-1:0] aw_idx, ar_idx, st_idx, ptr_inc;
    logic             wr_fire, wr_mapped, wr_csr, mem_we;
    logic             rd_fire, ar_mapped, ar_csr, ax_rd_en, st_rd_en;
    logic             csr_start, csr_clr, start_any, busy, beat_ok;
    logic [31:0]      csr_word;
    logic [1:0][31:0] bank_dout;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Handshakes: ready is offered combinationally only when no response is outstanding.
    assign aw_idx    = s_axi_awaddr[AXI_ADDR_W-1:2];
    assign ar_idx    = s_axi_araddr[AXI_ADDR_W-1:2];
    assign wr_fire   = s_axi_awvalid && s_axi_wvalid && !bvalid_q && !s_axi_areset;
    assign rd_fire   = s_axi_arvalid && !rvalid_q && !rd_pend_q && !s_axi_areset;
    assign wr_mapped = aw_idx < N_IDX;
    assign wr_csr    = aw_idx == CSR_IDX;
    assign ar_mapped = ar_idx < N_IDX;
    assign ar_csr    = ar_idx == CSR_IDX;
    assign mem_we    = wr_fire && wr_mapped;
    assign ax_rd_en  = rd_fire && ar_mapped;
    assign csr_start = wr_fire && wr_csr && s_axi_wstrb[0] && s_axi_wdata[0];
    assign csr_clr   = wr_fire && wr_csr && s_axi_wstrb[0] && s_axi_wdata[2];
    assign start_any = start || csr_start;
    assign busy      = state_q != IDLE;
    assign beat_ok   = tvalid_q && x_tready;
    assign ptr_inc   = ptr_q + 1'b1;
    assign csr_word  = {16'(frame_cnt_q), 13'd0, dropped_q, wr_bank_q, busy};

    // Each bank has one read port: the write bank serves AXI reads, the other serves the stream.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [31:0]      mem [0:N_WORDS-1];
        logic [31:0]      dout_q;
        logic             is_wr;
        logic             rd_en;
        logic [IDX_W-1:0] rd_idx;

        assign is_wr  = wr_bank_q == 1'(gi);
        assign rd_en  = is_wr ? ax_rd_en : st_rd_en;
        assign rd_idx = is_wr ? ar_idx : st_idx;

        always_ff @(posedge s_axi_aclk) begin
            if (mem_we && is_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_axi_wstrb[b]) begin
                        mem[aw_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                    end
                end
            end
            if (rd_en) begin
                dout_q <= mem[rd_idx];
            end
        end

        assign bank_dout[gi] = dout_q;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            wr_bank_q   <= 1'b0;
            dropped_q   <= 1'b0;
            frame_cnt_q <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            rd_pend_q   <= 1'b0;
            rd_map_q    <= 1'b0;
            rd_csr_q    <= 1'b0;
            rd_bank_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wr_bank_q   <= wr_bank_d;
            dropped_q   <= dropped_d;
            frame_cnt_q <= frame_cnt_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rd_pend_q   <= rd_pend_d;
            rd_map_q    <= rd_map_d;
            rd_csr_q    <= rd_csr_d;
            rd_bank_q   <= rd_bank_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_any) state_d = PRIME;
            PRIME:   state_d = STREAM;
            STREAM:  if (beat_ok && ptr_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stream datapath: the bank read is only enabled when the next word is needed,
    // so the registered read output doubles as the stall holding register.
    always_comb begin
        ptr_d       = ptr_q;
        wr_bank_d   = wr_bank_q;
        frame_cnt_d = frame_cnt_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        st_rd_en    = 1'b0;
        st_idx      = ptr_q;
        dropped_d   = dropped_q;
        case (state_q)
            IDLE: begin
                if (start_any) begin
                    wr_bank_d = !wr_bank_q;
                    ptr_d     = '0;
                end
            end
            PRIME: begin
                st_rd_en = 1'b1;
                tvalid_d = 1'b1;
                tlast_d  = LAST_IDX == '0;
            end
            STREAM: begin
                if (beat_ok) begin
                    if (ptr_q == LAST_IDX) begin
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end else begin
                        ptr_d    = ptr_inc;
                        st_idx   = ptr_inc;
                        st_rd_en = 1'b1;
                        tlast_d  = ptr_inc == LAST_IDX;
                    end
                end
            end
            default: ;
        endcase
        if (csr_clr) dropped_d = 1'b0;
        if (busy && start_any) dropped_d = 1'b1;
    end

    // AXI responses: read data is captured from the bank one cycle after the address beat.
    always_comb begin
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rd_pend_d = rd_fire;
        rd_map_d  = rd_map_q;
        rd_csr_d  = rd_csr_q;
        rd_bank_d = rd_bank_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = (wr_mapped || wr_csr) ? 2'b00 : 2'b10;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (rd_fire) begin
            rd_map_d  = ar_mapped;
            rd_csr_d  = ar_csr;
            rd_bank_d = wr_bank_q;
        end
        if (rd_pend_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_map_q ? bank_dout[rd_bank_q] : (rd_csr_q ? csr_word : 32'd0);
            rresp_d  = (rd_map_q || rd_csr_q) ? 2'b00 : 2'b10;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_comb begin
        s_axi_awready = wr_fire;
        s_axi_wready  = wr_fire;
        s_axi_bvalid  = bvalid_q;
        s_axi_bresp   = bresp_q;
        s_axi_arready = rd_fire;
        s_axi_rvalid  = rvalid_q;
        s_axi_rdata   = rdata_q;
        s_axi_rresp   = rresp_q;
        x_tvalid      = tvalid_q;
        x_tlast       = tlast_q;
        x_tdata       = wr_bank_q ? bank_dout[0] : bank_dout[1];
    end

endmodule

// File: doc/image_loader_pp.md
IMAGE_LOADER_PP -- requirements
Module: image_loader_pp

Interface
REQ-001 Parameter N_WORDS, default 784: image length in 32-bit words per frame.
REQ-002 Parameter AXI_ADDR_W, default 12: AXI-lite byte address width; N_WORDS SHALL be less than 2**(AXI_ADDR_W-2).
REQ-003 Parameter CNT_W, default 16: frame-counter width.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 s_axi_aclk  in  1  single clock; all logic on its rising edge.
REQ-006 s_axi_areset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to stream the loaded bank.
REQ-008 S_AXI_aw*/w*/b*/ar*/r*  AXI4-Lite slave: addr AXI_ADDR_W, data 32, wstrb 4, prot 3 (ignored), resp 2.
REQ-009 x_tdata  out  32  stream data.
REQ-010 x_tvalid  out  1  stream valid.
REQ-011 x_tready  in  1  stream ready.
REQ-012 x_tlast  out  1  high on word N_WORDS-1 of each frame.

Function
REQ-013 The block SHALL hold two banks of N_WORDS x 32: write bank (AXI-visible) and stream bank; wr_bank bit selects the write bank.
REQ-014 Word index = addr[AXI_ADDR_W-1:2]; index < N_WORDS maps to write bank; index 2**(AXI_ADDR_W-2)-1 is CSR; others unmapped.
REQ-015 Write: awready and wready SHALL pulse together for one cycle when awvalid, wvalid are both high and bvalid is low; bvalid SHALL assert the following cycle and hold until bready.
REQ-016 wstrb byte lanes SHALL be honoured; unmapped write SHALL change nothing and return bresp 2'b10, mapped writes 2'b00.
REQ-017 Read: arready SHALL pulse one cycle when arvalid high and rvalid low; rvalid SHALL assert exactly 2 cycles after the arready cycle, holding rdata stable until rready.
REQ-018 Unmapped read SHALL return rdata 0, rresp 2'b10.
REQ-019 CSR read: [0] busy, [1] wr_bank, [2] start_dropped (sticky), [31:16] frame count (zero-extended/truncated from CNT_W).
REQ-020 CSR write: bit0=1 SHALL act as start; bit2=1 SHALL clear start_dropped; other bits ignored.
REQ-021 FSM states IDLE, PRIME, STREAM; reset enters IDLE.
REQ-022 IDLE: start (port or CSR, same-cycle pair counts once) SHALL toggle wr_bank, zero the word pointer, go PRIME.
REQ-023 PRIME: one BRAM read cycle; x_tvalid SHALL be high exactly 2 cycles after the start cycle, carrying word 0.
REQ-024 STREAM: one beat per cycle while x_tready high; x_tdata/x_tvalid/x_tlast SHALL hold stable while x_tvalid high and x_tready low.
REQ-025 Beat N_WORDS-1 accepted: x_tvalid SHALL deassert next cycle, frame count +1 (wraps at 2**CNT_W), return IDLE; busy = state != IDLE.
REQ-026 Start while busy SHALL be ignored and set start_dropped.
REQ-027 AXI writes/reads during STREAM SHALL access only the write bank and SHALL not stall the stream.
REQ-028 N_WORDS = 1: first beat SHALL carry x_tlast.

Reset
REQ-029 During reset: x_tvalid, x_tlast, all AXI ready/valid outputs 0; resp 2'b00; wr_bank 0; frame count 0; start_dropped 0; state IDLE.
REQ-030 Reset mid-frame SHALL abort the stream with x_tvalid low the cycle after reset is sampled; bank contents are not cleared.

Verification
REQ-031 Write 784 words value i*3+1 to bank, pulse start, x_tready=1 -> 784 beats in 784 consecutive cycles, data i*3+1, x_tlast only on beat 783, CSR count 1.
REQ-032 During streaming write 0x1111_FADE to word 5, read back -> 0x1111_FADE, rresp 0; streamed word 5 unchanged.
REQ-033 Random x_tready toggling -> no beat lost/duplicated, data stable while stalled.
REQ-034 Start pulsed while busy -> ignored, CSR bit2=1; CSR write 0x4 -> bit2=0.
REQ-035 Write/read index 800 -> bresp/rresp 2'b10, rdata 0, bank unchanged; wstrb 4'b0011 write of 0xAAAA_BBBB over 0 -> read 0x0000_BBBB.
REQ-036 Assert reset at beat 100 -> x_tvalid 0 next cycle, CSR reads 0 after reset.
